serial_divider: RTL
===================

// Module: serial_divider
// PURPOSE
//  Sequential unsigned restoring divider, N-bit dividend / N-bit divisor, one quotient bit per clock.
//  Inverse companion of the serial booth multiplier; same start/ready handshake so both share a control FSM/bench style.
//  Sits in the serial arithmetic unit beside the multiplier; results held until next start.
// PARAMETERS
//  N      8   operand width (dividend, divisor, quotient, remainder); N >= 2
//  CNT_W  4   iteration counter width; must satisfy 2**CNT_W > N
// PORTS
//  clk          input   1    system clock, all state updates on rising edge
//  rst          input   1    synchronous reset, active-high
//  start        input   1    launch request, sampled on rising edge while idle
//  A            input   N    dividend, captured on start edge only
//  B            input   N    divisor, captured on start edge only
//  Quotient     output  N    quotient, valid while ready=1 after completion
//  Remainder    output  N    remainder, valid while ready=1 after completion
//  ready        output  1    1 = idle, result (if any) valid; 0 = busy
//  div_by_zero  output  1    1 = last operation had B==0; held with result
//  sub_output   output  N+1  debug: current trial difference {R,Q[N-1]} - {0,B}, combinational
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; Quotient=0, Remainder=0, ready=1, div_by_zero=0, counter=0.
//   rst dominates start on the same edge; rst mid-operation aborts, no partial result kept.
//  States: IDLE, RUN, DONE(single-cycle internal) -> ready high in IDLE only.
//  IDLE: start=1 at edge e0 -> capture A into Q reg, B into D reg, R<=0, cnt<=0, ready<=0, div_by_zero<=0, go RUN.
//   A/B ignored (may be X) after e0.
//  RUN, each edge: trial = {R[N-1:0],Q[N-1]} - {1'b0,D} (N+1 bits).
//   trial[N]==0 -> R<=trial[N-1:0], Q<={Q[N-2:0],1}; else R<={R[N-2:0],Q[N-1]}, Q<={Q[N-2:0],0}.
//   cnt increments; on Nth RUN edge (e0+N) Quotient<=Q, Remainder<=R, ready<=1, go IDLE.
//  Latency: ready=1 and results valid immediately after edge e0+N (N=8: 8 edges after start edge).
//  Divide by zero: D==0 at first RUN edge (e0+1) -> Quotient=all 1s, Remainder=dividend,
//   div_by_zero=1, ready=1, go IDLE; no iteration performed.
//  start while busy (ready=0): ignored, no restart, no queueing.
//  start held high: re-launch on first edge with ready=1 (back-to-back, no idle gap required);
//   Quotient/Remainder/div_by_zero of previous op stay stable until overwritten at completion.
//  Quotient/Remainder change only at completion or reset; never mid-iteration.
//  All arithmetic unsigned; result identities: A == Quotient*B + Remainder, Remainder < B (B!=0).
// TESTING
//  1. Reset then idle: rst 2 cycles -> ready=1, Quotient=0, Remainder=0, div_by_zero=0.
//  2. A=200, B=7, start 1 cycle -> ready=0 for 8 edges, then Quotient=28 (0x1C), Remainder=4, ready=1.
//  3. Edges: A=255,B=1 -> Q=255,R=0; A=5,B=9 -> Q=0,R=5; A=255,B=255 -> Q=1,R=0.
//  4. A=100,B=0 -> after 1 edge ready=1, Q=0xFF, R=0x64, div_by_zero=1; next op 81/9 -> Q=9,R=0, div_by_zero=0.
//  5. Start 200/7, rst at edge e0+4 -> ready=1, Q=0, R=0 next cycle; start pulse at e0+2 during run ignored.
//  6. 1000 random A,B (B!=0), start held high back-to-back -> each result == A/B, A%B; bench checks 8-edge latency.

Source files
------------

// File: rtl/serial_divider.sv
// Sequential unsigned restoring divider: N-bit / N-bit, one quotient bit per clock,
// start/ready handshake shared with the serial multiplier. Results hold until the next completion.
module serial_divider #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [N-1:0]   Quotient,
    output logic [N-1:0]   Remainder,
    output logic           ready,
    output logic           div_by_zero,
    output logic [N:0]     sub_output
);

    localparam int unsigned TW = N + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [N-1:0]       q_reg;
    logic [N-1:0]       d_reg;
    logic [N-1:0]       r_reg;
    logic [CNT_W-1:0]   cnt;

    logic [TW-1:0]      trial;
    logic [N-1:0]       next_q;
    logic [N-1:0]       next_r;
    logic               last_iter;
    logic               d_zero;

    // Trial subtraction of the divisor from the partial remainder shifted left by one
    always_comb begin
        trial  = {r_reg, q_reg[N-1]} - {1'b0, d_reg};
        next_q = {q_reg[N-2:0], 1'b0};
        next_r = {r_reg[N-2:0], q_reg[N-1]};
        if (!trial[N]) begin
            next_q = {q_reg[N-2:0], 1'b1};
            next_r = trial[N-1:0];
        end
    end

    assign sub_output = trial;
    assign last_iter  = (cnt == CNT_W'(N - 1));
    assign d_zero     = (d_reg == '0);

    // Next-state logic: a zero divisor or the final iteration returns to idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (d_zero || last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand capture, iteration datapath and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            ready       <= 1'b1;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg       <= A;
                        d_reg       <= B;
                        r_reg       <= '0;
                        cnt         <= '0;
                        ready       <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    if (d_zero) begin
                        // Divide by zero: report all-ones quotient and pass the dividend through
                        Quotient    <= '1;
                        Remainder   <= q_reg;
                        div_by_zero <= 1'b1;
                        ready       <= 1'b1;
                    end else begin
                        q_reg <= next_q;
                        r_reg <= next_r;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            Quotient  <= next_q;
                            Remainder <= next_r;
                            ready     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
